fifo_wr_arbiter: RTL and testbench

Round-robin write arbiter that shares one `bram_fifo` 72-bit input stream between `NUM_REQ` producers. Each producer gets a grant for a burst that ends on its `last` beat or after `MAX_BURST` beats, whichever comes first. Beats are forwarded through one registered output stage into the FIFO's `ss_*` port, with the source index tagged alongside. The block sits directly in front of the FIFO in the accelerator wrapper.

---
 rtl/fifo_wr_arbiter_pkg.sv | 16 +
 rtl/fifo_wr_arbiter_if.sv | 28 ++
 rtl/fifo_wr_arbiter_rr_picker.sv | 36 +++
 rtl/fifo_wr_arbiter.sv | 120 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the round-robin FIFO write arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  localparam int unsigned STATS_W = 32;

  function automatic int unsigned wrap_add(input int unsigned a, input int unsigned b,
                                           input int unsigned n);
    return (a + b) % n;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester-side and FIFO-side stream bundle for fifo_wr_arbiter.
interface fifo_wr_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 72
);
  localparam int unsigned SRC_W = $clog2(NUM_REQ);

  logic [NUM_REQ*DATA_W-1:0] ss_data;
  logic [NUM_REQ-1:0]        ss_valid;
  logic [NUM_REQ-1:0]        ss_last;
  logic [NUM_REQ-1:0]        ss_ready;
  logic [DATA_W-1:0]         ms_data;
  logic                      ms_valid;
  logic                      ms_last;
  logic [SRC_W-1:0]          ms_src;
  logic                      ms_ready;

  modport slave (
    input  ss_data, ss_valid, ss_last, ms_ready,
    output ss_ready, ms_data, ms_valid, ms_last, ms_src
  );

  modport master (
    output ss_data, ss_valid, ss_last, ms_ready,
    input  ss_ready, ms_data, ms_valid, ms_last, ms_src
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, modulo NUM_REQ.
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned SRC_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [SRC_W-1:0]   ptr,
  output logic               any,
  output logic [SRC_W-1:0]   idx
);

  logic [SRC_W-1:0] w_cand [NUM_REQ];
  logic             w_found;

  always_comb begin
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_cand[k] = SRC_W'(wrap_add(32'(ptr), k, NUM_REQ));
    end
  end

  always_comb begin
    w_found = 1'b0;
    idx     = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!w_found && req[w_cand[k]]) begin
        idx     = w_cand[k];
        w_found = 1'b1;
      end
    end
  end

  assign any = w_found;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst write arbiter in front of bram_fifo with a registered output stage.
// Optional per-requester accepted-beat counters: define FIFO_ARB_STATS_EN.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_W    = 72,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic               clk,
  input  logic               resetn,
  fifo_wr_arbiter_if.slave   bus
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STATS_W-1:0] beat_cnt
`endif
);

  localparam int unsigned SRC_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);
  localparam logic [SRC_W-1:0] SRC_MAX  = SRC_W'(NUM_REQ - 1);

  arb_state_t        r_state, w_state_nxt;
  logic [SRC_W-1:0]  r_gnt_idx, r_rr_ptr, w_pick_idx, w_gnt_nxt;
  logic              w_pick_any;
  logic [CNT_W-1:0]  r_burst_cnt;
  logic [DATA_W-1:0] r_ms_data, w_gnt_data;
  logic              r_ms_valid, r_ms_last;
  logic [SRC_W-1:0]  r_ms_src;
  logic              w_slot_free, w_accept, w_beat_last, w_burst_end;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_pick (
    .req (bus.ss_valid),
    .ptr (r_rr_ptr),
    .any (w_pick_any),
    .idx (w_pick_idx)
  );

  // Output slot can take a beat when empty or draining this cycle.
  assign w_slot_free = !r_ms_valid || bus.ms_ready;
  assign w_gnt_data  = bus.ss_data[32'(r_gnt_idx)*DATA_W +: DATA_W];
  assign w_accept    = (r_state == BURST) && w_slot_free && bus.ss_valid[r_gnt_idx];
  assign w_beat_last = bus.ss_last[r_gnt_idx] || (r_burst_cnt == CNT_LAST);
  assign w_burst_end = w_accept && w_beat_last;
  assign w_gnt_nxt   = (r_gnt_idx == SRC_MAX) ? '0 : r_gnt_idx + SRC_W'(1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_pick_any)  w_state_nxt = BURST;
      BURST:   if (w_burst_end) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.ss_ready = '0;
    if (r_state == BURST) bus.ss_ready[r_gnt_idx] = w_slot_free;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_gnt_idx   <= '0;
      r_rr_ptr    <= '0;
      r_burst_cnt <= '0;
    end else begin
      if (r_state == IDLE && w_pick_any) begin
        r_gnt_idx   <= w_pick_idx;
        r_burst_cnt <= '0;
      end else if (w_accept) begin
        r_burst_cnt <= r_burst_cnt + CNT_W'(1);
      end
      if (w_burst_end) r_rr_ptr <= w_gnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ms_data  <= '0;
      r_ms_valid <= 1'b0;
      r_ms_last  <= 1'b0;
      r_ms_src   <= '0;
    end else if (w_accept) begin
      r_ms_data  <= w_gnt_data;
      r_ms_valid <= 1'b1;
      r_ms_last  <= w_beat_last;
      r_ms_src   <= r_gnt_idx;
    end else if (bus.ms_ready) begin
      r_ms_valid <= 1'b0;
    end
  end

  assign bus.ms_data  = r_ms_data;
  assign bus.ms_valid = r_ms_valid;
  assign bus.ms_last  = r_ms_last;
  assign bus.ms_src   = r_ms_src;

`ifdef FIFO_ARB_STATS_EN
  logic [STATS_W-1:0] r_beat_cnt [NUM_REQ];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) r_beat_cnt[i] <= '0;
    end else if (w_accept) begin
      r_beat_cnt[r_gnt_idx] <= r_beat_cnt[r_gnt_idx] + STATS_W'(1);
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) beat_cnt[i*STATS_W +: STATS_W] = r_beat_cnt[i];
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed + randomized scoreboard bench for fifo_wr_arbiter (4 requesters, 72-bit, MAX_BURST 8).
module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int DW = 72;
  localparam int MB = 8;

  typedef struct { logic [DW-1:0] d; logic l; } beat_t;
  typedef struct { logic [DW-1:0] d; int s; logic l; } exp_t;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();
`ifdef FIFO_ARB_STATS_EN
  logic [NR*32-1:0] beat_cnt;
`endif

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
`ifdef FIFO_ARB_STATS_EN
    ,
    .beat_cnt (beat_cnt)
`endif
  );

  beat_t pq [NR][$];
  exp_t  sb [$];
  int    out_src [$];
  int    out_cyc [$];
  int    bcnt [NR];
  int    acc [NR];
  int    cyc, n_tests, n_fail;
  bit    gap_en, rdy_rand;
  logic  rdy_val;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push(input int r, input logic [DW-1:0] d, input logic l);
    beat_t b;
    b.d = d;
    b.l = l;
    pq[r].push_back(b);
  endtask

  function automatic bit busy();
    busy = (sb.size() != 0) || (bus.ms_valid === 1'b1);
    for (int i = 0; i < NR; i++) if (pq[i].size() != 0) busy = 1'b1;
  endfunction

  // One clock: observe handshakes at negedge, then drive new inputs 1 time unit after posedge.
  task automatic cycle();
    logic [NR-1:0] xfer;
    exp_t  e;
    beat_t b;
    bit    held;
    @(negedge clk);
    xfer = bus.ss_valid & bus.ss_ready;
    for (int i = 0; i < NR; i++) begin
      if (xfer[i] && pq[i].size() != 0) begin
        b = pq[i].pop_front();
        acc[i]++;
        bcnt[i]++;
        e.d = b.d;
        e.s = i;
        e.l = b.l || (bcnt[i] == MB);
        if (e.l) bcnt[i] = 0;
        sb.push_back(e);
      end
    end
    if (bus.ms_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("orphan_beat", bus.ms_valid, 0);
      end else if (bus.ms_ready) begin
        e = sb.pop_front();
        chk("out_data", bus.ms_data, e.d);
        chk("out_src", bus.ms_src, e.s);
        chk("out_last", bus.ms_last, e.l);
        out_src.push_back(int'(bus.ms_src));
        out_cyc.push_back(cyc);
      end else begin
        chk("stall_data", bus.ms_data, sb[0].d);
        chk("stall_ss_ready", bus.ss_ready, 0);
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    for (int i = 0; i < NR; i++) begin
      held = bus.ss_valid[i] && !xfer[i];
      if (pq[i].size() > 0 && (held || !gap_en || $urandom_range(0, 3) != 0)) begin
        bus.ss_valid[i]             = 1'b1;
        bus.ss_data[i*DW +: DW]     = pq[i][0].d;
        bus.ss_last[i]              = pq[i][0].l;
      end else begin
        bus.ss_valid[i] = 1'b0;
      end
    end
    bus.ms_ready = rdy_rand ? ($urandom_range(0, 2) != 0) : rdy_val;
  endtask

  task automatic drain(input int budget, input string tag);
    int k;
    k = 0;
    while (busy() && k < budget) begin
      cycle();
      k++;
    end
    chk(tag, busy(), 0);
  endtask

  task automatic do_reset(input string pfx);
    resetn = 1'b0;
    #1;
    for (int i = 0; i < NR; i++) begin
      pq[i].delete();
      bcnt[i] = 0;
      acc[i]  = 0;
    end
    sb.delete();
    out_src.delete();
    out_cyc.delete();
    bus.ss_valid = '0;
    bus.ss_last  = '0;
    bus.ss_data  = '0;
    bus.ms_ready = 1'b1;
    rdy_val  = 1'b1;
    rdy_rand = 1'b0;
    gap_en   = 1'b0;
    chk({pfx, "_ms_valid"}, bus.ms_valid, 0);
    chk({pfx, "_ms_data"}, bus.ms_data, 0);
    chk({pfx, "_ms_last"}, bus.ms_last, 0);
    chk({pfx, "_ms_src"}, bus.ms_src, 0);
    chk({pfx, "_ss_ready"}, bus.ss_ready, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int vcyc, k, total, len;
    int exp_s [$];
    logic [DW-1:0] d;
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    bus.ss_valid = '0;
    bus.ss_last  = '0;
    bus.ss_data  = '0;
    bus.ms_ready = 1'b1;
    #2;
    do_reset("rst");

    // Single requester: 3 beats, last on the third.
    for (int n = 1; n <= 3; n++) push(0, DW'(n), n == 3);
    cycle();
    vcyc = cyc;
    drain(50, "single_drain");
    chk("single_count", out_src.size(), 3);
    if (out_cyc.size() > 0) chk("single_latency", out_cyc[0] - vcyc, 2);

    // Round-robin with 1-beat packets on every requester.
    do_reset("rst_rr");
    for (int n = 0; n < 10; n++)
      for (int r = 0; r < NR; r++) push(r, DW'((r << 8) | n), 1'b1);
    drain(200, "rr_drain");
    chk("rr_count", out_src.size(), 40);
    for (int i = 0; i < out_src.size(); i++) begin
      chk("rr_order", out_src[i], i % NR);
      if (i > 0) chk("rr_spacing", out_cyc[i] - out_cyc[i-1], 2);
    end
`ifdef FIFO_ARB_STATS_EN
    for (int r = 0; r < NR; r++) chk("beat_cnt", beat_cnt[r*32 +: 32], 10);
`endif

    // Burst cap: req2 streams 20 beats (only the 20th flagged), req3 interleaves.
    do_reset("rst_cap");
    for (int n = 1; n <= 20; n++) push(2, DW'('h200 + n), n == 20);
    for (int n = 1; n <= 3; n++) push(3, DW'('h300 + n), 1'b1);
    drain(200, "cap_drain");
    for (int i = 0; i < 8; i++) exp_s.push_back(2);
    exp_s.push_back(3);
    for (int i = 0; i < 8; i++) exp_s.push_back(2);
    exp_s.push_back(3);
    for (int i = 0; i < 4; i++) exp_s.push_back(2);
    exp_s.push_back(3);
    chk("cap_count", out_src.size(), exp_s.size());
    for (int i = 0; i < out_src.size() && i < exp_s.size(); i++) chk("cap_order", out_src[i], exp_s[i]);

    // Directed backpressure: 5 stalled cycles mid-burst.
    do_reset("rst_bp");
    for (int n = 1; n <= 6; n++) push(1, DW'('h100 + n), n == 6);
    k = 0;
    while (out_src.size() < 2 && k < 50) begin
      cycle();
      k++;
    end
    chk("bp_reach", out_src.size(), 2);
    rdy_val      = 1'b0;
    bus.ms_ready = 1'b0;
    repeat (4) begin
      cycle();
      chk("bp_hold_valid", bus.ms_valid, 1);
    end
    rdy_val = 1'b1;
    cycle();
    chk("bp_hold_valid", bus.ms_valid, 1);
    drain(100, "bp_drain");
    chk("bp_count", out_src.size(), 6);

    // Random valid gaps and random ms_ready.
    do_reset("rst_rand");
    gap_en   = 1'b1;
    rdy_rand = 1'b1;
    total    = 0;
    for (int c = 0; c < 10000; c++) begin
      for (int r = 0; r < NR; r++) begin
        if (pq[r].size() < 2) begin
          len = $urandom_range(1, 12);
          for (int j = 0; j < len; j++) begin
            d = DW'({$urandom(), $urandom(), $urandom()});
            push(r, d, j == len - 1);
          end
          total += len;
        end
      end
      cycle();
    end
    drain(4000, "rand_drain");
    chk("rand_count", out_src.size(), total);

    // Reset during beat 2 of a 4-beat burst, with rr_ptr already advanced.
    do_reset("rst_mid");
    push(0, DW'('h0A), 1'b1);
    drain(50, "mid_pre_drain");
    for (int n = 1; n <= 4; n++) push(2, DW'('h20 + n), n == 4);
    k = 0;
    while (acc[2] < 2 && k < 50) begin
      cycle();
      k++;
    end
    chk("mid_reach", acc[2], 2);
    #2;
    do_reset("mid_rst");
    push(3, DW'('h31), 1'b1);
    push(0, DW'('h01), 1'b1);
    drain(50, "mid_post_drain");
    chk("mid_count", out_src.size(), 2);
    if (out_src.size() >= 2) begin
      chk("mid_first_grant", out_src[0], 0);
      chk("mid_second_grant", out_src[1], 3);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
